// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencing and status for a register-file FIFO datapath.
// Decodes write/read requests into the register-file write enable and the
// output-latch load enable, keeps the read and write pointers and the
// occupancy count, and drives the handshake and status flags. No data lives here.
module fifo_ctrl #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count
);

  // Occupancy value meaning "every entry holds data" (2**AW).
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    WR_ERR = 3'd3,
    READ   = 3'd4,
    RD_ERR = 3'd5
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  // Status comes straight from the registered count, so it shows the
  // post-operation occupancy one cycle after the request edge.
  assign full       = (count_reg == DEPTH_CNT);
  assign empty      = (count_reg == '0);
  assign mem_waddr  = wr_ptr_reg;
  assign mem_raddr  = rd_ptr_reg;
  assign data_count = count_reg;

  // State register; INIT is held only while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a lone request is accepted or rejected according to the
  // current fill level; simultaneous requests are both ignored.
  always_comb begin
    state_next = NO_OP;
    if (wr_req && !rd_req) begin
      state_next = full ? WR_ERR : WRITE;
    end else if (rd_req && !wr_req) begin
      state_next = empty ? RD_ERR : READ;
    end
  end

  // Outputs: enables follow the live requests, flags follow the state register.
  always_comb begin
    mem_we = wr_req && !rd_req && !full;
    mem_re = rd_req && !wr_req && !empty;
    wr_ack = (state_reg == WRITE);
    wr_err = (state_reg == WR_ERR);
    rd_ack = (state_reg == READ);
    rd_err = (state_reg == RD_ERR);
  end

  // Pointers and count move on the edge that enters WRITE or READ; the
  // datapath uses the old pointer value on that same edge. Pointers wrap freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (state_next == WRITE) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        count_reg  <= count_reg + 1'b1;
      end else if (state_next == READ) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg  <= count_reg - 1'b1;
      end
    end
  end

  // Occupancy must stay within 0..2**AW; an underflow wraps above the limit,
  // so one bound check covers both directions.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_reg <= DEPTH_CNT)
        else $error("fifo_ctrl: occupancy out of range: %0d", count_reg);
      assert (!(mem_we && mem_re))
        else $error("fifo_ctrl: write and read enables both high");
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table-driven check of fifo_ctrl with a scoreboard of
// expected post-edge register values, plus hand-written reset sequences.
module tb_fifo_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          reset_n;
  logic          wr_req;
  logic          rd_req;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [AW:0]   data_count;

  fifo_ctrl #(.AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_waddr  (mem_waddr),
    .mem_raddr  (mem_raddr),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, the enables expected during that cycle, and the
  // register values expected after the edge that samples the inputs.
  typedef struct {
    logic wr;
    logic rd;
    logic we;
    logic re;
    int   wa;
    int   ra;
    int   cnt;
    logic fu;
    logic em;
    logic wack;
    logic werr;
    logic rack;
    logic rerr;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   txn    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endfunction

  function automatic void add(input logic wr, input logic rd, input logic we, input logic re,
                              input int wa, input int ra, input int cnt,
                              input logic fu, input logic em,
                              input logic wack, input logic werr, input logic rack, input logic rerr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.we = we; v.re = re;
    v.wa = wa; v.ra = ra; v.cnt = cnt; v.fu = fu; v.em = em;
    v.wack = wack; v.werr = werr; v.rack = rack; v.rerr = rerr;
    vq.push_back(v);
  endfunction

  task automatic check_regs(input vec_t e, input string tag);
    chk({tag, " mem_waddr"}, 32'(mem_waddr), 32'(e.wa));
    chk({tag, " mem_raddr"}, 32'(mem_raddr), 32'(e.ra));
    chk({tag, " data_count"}, 32'(data_count), 32'(e.cnt));
    chk({tag, " full"}, 32'(full), 32'(e.fu));
    chk({tag, " empty"}, 32'(empty), 32'(e.em));
    chk({tag, " wr_ack"}, 32'(wr_ack), 32'(e.wack));
    chk({tag, " wr_err"}, 32'(wr_err), 32'(e.werr));
    chk({tag, " rd_ack"}, 32'(rd_ack), 32'(e.rack));
    chk({tag, " rd_err"}, 32'(rd_err), 32'(e.rerr));
  endtask

  // Drive each queued vector after a falling edge, check the enables, push the
  // expectation, then pop and compare just after the next rising edge.
  task automatic run_vectors();
    vec_t v;
    vec_t e;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(negedge clk);
      wr_req = v.wr;
      rd_req = v.rd;
      #1;
      chk("mem_we", 32'(mem_we), 32'(v.we));
      chk("mem_re", 32'(mem_re), 32'(v.re));
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_regs(e, "post");
      $display("txn %0d: wr=%0b rd=%0b we=%0b re=%0b waddr=%0d raddr=%0d count=%0d full=%0b empty=%0b flags(wa/we/ra/re)=%0b%0b%0b%0b",
               txn, v.wr, v.rd, mem_we, mem_re, mem_waddr, mem_raddr, data_count, full, empty,
               wr_ack, wr_err, rd_ack, rd_err);
      txn++;
    end
  endtask

  // Mid-cycle asynchronous reset with requests low: everything must clear
  // before any clock edge arrives.
  task automatic async_reset_check();
    vec_t z;
    #2;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    reset_n = 1'b0;
    #1;
    z.wa = 0; z.ra = 0; z.cnt = 0; z.fu = 1'b0; z.em = 1'b1;
    z.wack = 1'b0; z.werr = 1'b0; z.rack = 1'b0; z.rerr = 1'b0;
    check_regs(z, "async_rst");
    chk("async_rst mem_we", 32'(mem_we), 32'd0);
    chk("async_rst mem_re", 32'(mem_re), 32'd0);
    $display("txn %0d: async reset mid-cycle count=%0d empty=%0b", txn, data_count, empty);
    txn++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t r;
    reset_n = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    r.wa = 0; r.ra = 0; r.cnt = 0; r.fu = 1'b0; r.em = 1'b1;
    r.wack = 1'b0; r.werr = 1'b0; r.rack = 1'b0; r.rerr = 1'b0;
    check_regs(r, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Fill: write pointer steps through every entry and wraps to 0.
    for (int i = 0; i < 8; i++) add(1, 0, 1, 0, (i + 1) % 8, 0, i + 1, (i == 7), 0, 1, 0, 0, 0);
    // Write while full is rejected.
    add(1, 0, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0);
    // Drain: read pointer steps through every entry and wraps to 0.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 0, (i + 1) % 8, 7 - i, 0, (i == 7), 0, 0, 1, 0);
    // Read while empty is rejected.
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Three entries, then simultaneous requests are ignored.
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, i + 1, 0, i + 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    // Two more writes so reset has something to clear.
    for (int i = 0; i < 2; i++) add(1, 0, 1, 0, 4 + i, 0, 4 + i, 0, 0, 1, 0, 0, 0);
    run_vectors();

    async_reset_check();

    // Write 5, read 5, write 6: write pointer wraps across 7 -> 0.
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, i + 1, 0, i + 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 5, i + 1, 4 - i, 0, (i == 4), 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 0, (6 + i) % 8, 5, i + 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 3, 5, 6, 0, 0, 0, 0, 0, 0);
    run_vectors();

    async_reset_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Control/sequencing block for the FIFO datapath, which is a register file of 4-bit resettable flip-flops plus a registered output stage. It decodes write and read requests into register-file write enables and read/write addresses, and tracks occupancy. It also drives the handshake and status flags (ack, error, full, empty, count). It contains no data path; data storage and output latching live in the datapath.

Parameters:
- AW, 3, address width; FIFO depth = 2**AW entries (default 8).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- wr_req  input  1  write request, sampled at rising edge
- rd_req  input  1  read request, sampled at rising edge
- mem_we  output  1  register-file write enable (combinational)
- mem_re  output  1  output-latch load enable for the datapath (combinational)
- mem_waddr  output  AW  write pointer (registered)
- mem_raddr  output  AW  read pointer (registered)
- full  output  1  count == 2**AW (registered)
- empty  output  1  count == 0 (registered)
- wr_ack  output  1  previous cycle's write accepted (registered)
- wr_err  output  1  previous cycle's write rejected (registered)
- rd_ack  output  1  previous cycle's read accepted (registered)
- rd_err  output  1  previous cycle's read rejected (registered)
- data_count  output  AW+1  current occupancy (registered)

Behaviour:
- Reset is asynchronous, active-low, on clock clk.
- Reset values:
  - state = INIT
  - wr_ptr = rd_ptr = 0; count = 0
  - empty = 1, full = 0
  - all ack/err flags = 0
- States: INIT, NO_OP, WRITE, WR_ERR, READ, RD_ERR. The state is a 3-bit register.
- Next state, evaluated at each rising edge from the current sampled inputs and current count:
  - wr_req & ~rd_req & ~full -> WRITE
  - wr_req & ~rd_req & full -> WR_ERR
  - rd_req & ~wr_req & ~empty -> READ
  - rd_req & ~wr_req & empty -> RD_ERR
  - wr_req & rd_req -> NO_OP (both ignored; no ack, no err)
  - neither request -> NO_OP
  - INIT is left on the first edge after reset release, using the same rules.
- Combinational enables:
  - mem_we = wr_req & ~rd_req & ~full
  - mem_re = rd_req & ~wr_req & ~empty
- On entering WRITE: wr_ptr += 1 modulo 2**AW; count += 1. The datapath writes at the old mem_waddr on that same edge.
- On entering READ: rd_ptr += 1 modulo 2**AW; count -= 1. The datapath latches the entry at the old mem_raddr into its output register on that same edge.
- Flags decode from the state register:
  - wr_ack = (state == WRITE); wr_err = (state == WR_ERR)
  - rd_ack = (state == READ); rd_err = (state == RD_ERR)
  - Each flag is high for exactly one cycle per accepted or rejected request.
- full and empty are decoded from the registered count, so they reflect the post-operation value one cycle after the request edge.
- Pointer wrap: increments from 2**AW-1 to 0, with no sticky bit. Full versus empty is distinguished only by count.
- Error cases leave pointers and count unchanged.
- Back-to-back requests are supported every cycle; throughput is 1 operation per cycle.
- Reset asserted mid-stream: all registers return to reset values immediately and asynchronously. mem_we and mem_re fall as soon as empty = 1 and full = 0, provided requests are low.
- count never exceeds 2**AW and never underflows; any other condition is an implementation bug and must be checked by assertion.

Test Plan:
- Reset release, idle 3 cycles: empty = 1, full = 0, data_count = 0, all ack/err = 0, mem_waddr = mem_raddr = 0.
- 8 consecutive writes: mem_we high in each cycle; mem_waddr steps 0..7 then wraps to 0; wr_ack high 8 cycles; data_count = 8; full = 1.
- 9th write while full: mem_we = 0, wr_err pulses 1 cycle, data_count stays 8, mem_waddr stays 0.
- 8 reads, then a 9th read: mem_raddr steps 0..7 and wraps to 0; rd_ack high 8 cycles; empty = 1; the 9th read gives rd_err = 1 with count still 0.
- Simultaneous wr_req = rd_req = 1 with count = 3: no enables, no flags, count stays 3, pointers unchanged.
- Write 5, read 5, then write 6 (pointer wrap across index 7 -> 0): data_count = 6, mem_waddr = 3, mem_raddr = 5. Assert reset_n low mid-cycle: outputs return to reset values without waiting for a clock edge.
